// File: rtl/dac_pkg.sv
// Shared definitions for the MCP4911-class DAC transmitter: FSM encoding,
// command-word bit positions and the command framing helper.
package dac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } dac_state_e;

  localparam int unsigned CMD_WR     = 15;
  localparam int unsigned CMD_BUF    = 14;
  localparam int unsigned CMD_GA     = 13;
  localparam int unsigned CMD_SHDN   = 12;
  localparam int unsigned DATA_MSB   = 11;
  localparam int unsigned FRAME_BITS = 16;

  function automatic logic [FRAME_BITS-1:0] dac_cmd(input logic       buf_bit,
                                                    input logic       ga_bit,
                                                    input logic [9:0] code);
    logic [FRAME_BITS-1:0] w;
    w               = '0;
    w[CMD_WR]       = 1'b0;
    w[CMD_BUF]      = buf_bit;
    w[CMD_GA]       = ga_bit;
    w[CMD_SHDN]     = 1'b1;
    w[DATA_MSB -: 10] = code;
    return w;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while enabled,
// restarting from a full count whenever the enable is low.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == '0) begin
      cnt_d = Reload;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Frames each 10-bit sample into a 16-bit DAC write, shifts it out in SPI mode 0,0,
// pulses the latch, and holds one further sample pending while a frame is in flight.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25,
  parameter bit          BUF_EN  = 1'b0,
  parameter bit          GAIN_1X = 1'b1
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld_n
);

  dac_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  sck_q, sck_d, cs_n_q, cs_n_d, ld_n_q, ld_n_d, done_q, done_d;
  logic [9:0]            pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d, overrun_q, overrun_d;
  logic                  tick, load_busy, pend_any, last_fall;
  logic [9:0]            pend_data;

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_i (sysclk),
    .rst_ni(rst_n),
    .en_i  (state_q != StIdle),
    .tick_o(tick)
  );

  // A load during busy lands in pending; at LATCH end that includes a same-cycle load.
  assign load_busy = load && (state_q != StIdle);
  assign pend_any  = load_busy || pend_vld_q;
  assign pend_data = load_busy ? data_in : pend_q;
  assign last_fall = tick && sck_q && (bit_cnt_q == 4'(FRAME_BITS - 1));

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load) state_d = StShift;
      StShift: if (last_fall) state_d = StLatch;
      StLatch: if (tick) state_d = pend_any ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    ld_n_d     = ld_n_q;
    done_d     = 1'b0;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = overrun_q || (load_busy && pend_vld_q);
    if (load_busy) begin
      pend_d     = data_in;
      pend_vld_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (load) begin
          shreg_d   = dac_cmd(BUF_EN, GAIN_1X, data_in);
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
        end
      end
      StShift: begin
        if (tick && !sck_q) begin
          sck_d = 1'b1;
        end else if (tick) begin
          sck_d = 1'b0;
          if (last_fall) begin
            shreg_d = '0;
            cs_n_d  = 1'b1;
            ld_n_d  = 1'b0;
          end else begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StLatch: begin
        if (tick) begin
          ld_n_d = 1'b1;
          done_d = 1'b1;
          if (pend_any) begin
            shreg_d    = dac_cmd(BUF_EN, GAIN_1X, pend_data);
            bit_cnt_d  = '0;
            cs_n_d     = 1'b0;
            pend_vld_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      ld_n_q     <= 1'b1;
      done_q     <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      ld_n_q     <= ld_n_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign dac_cs_n = cs_n_q;
  assign dac_sck  = sck_q;
  assign dac_sdi  = shreg_q[FRAME_BITS-1];
  assign dac_ld_n = ld_n_q;

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Serial transmitter that takes each 10-bit processed sample produced by the audio processing path and writes it to an MCP4911-class 10-bit SPI DAC.
- Sits at the output end of the sample pipeline: the processor presents a sample plus a one-cycle strobe; this block frames a 16-bit command word, shifts it out MSB first, then pulses the DAC latch.
- A one-deep pending buffer absorbs a sample that arrives while a frame is still in flight.

Parameters:
- CLK_DIV, 25: sysclk cycles per SCK half-period; minimum 2. At 50 MHz this gives 1 MHz SCK.
- BUF_EN, 0: value of the command BUF bit (bit 14).
- GAIN_1X, 1: value of the command GA_n bit (bit 13); 1 selects 1x gain.

Ports:
- sysclk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- data_in, input, 10: unsigned DAC code, offset binary (processor output already includes the DAC offset).
- load, input, 1: one-cycle strobe; data_in is valid in the same cycle.
- busy, output, 1: high while a frame or latch pulse is in progress.
- done, output, 1: one-cycle pulse when a frame completes.
- overrun, output, 1: sticky; set when a pending sample is overwritten. Cleared only by reset.
- dac_cs_n, output, 1: SPI chip select, active low.
- dac_sck, output, 1: SPI clock; idles low (mode 0,0).
- dac_sdi, output, 1: SPI data to DAC.
- dac_ld_n, output, 1: DAC latch strobe, active low.

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE.
  - Outputs: busy=0, done=0, overrun=0, dac_cs_n=1, dac_sck=0, dac_sdi=0, dac_ld_n=1.
  - Pending buffer empty. Any in-flight frame is abandoned; no partial latch.
- Command word: {1'b0, BUF_EN, GAIN_1X, 1'b1 (SHDN_n), data_in[9:0], 2'b00}.
- FSM states: IDLE -> SHIFT -> LATCH -> IDLE, or LATCH -> SHIFT if a sample is pending.
- IDLE: load=1 at edge k loads the shift register and enters SHIFT.
  - From edge k onward: cs_n=0, sdi=bit15, sck=0, busy=1.
- SHIFT: a divider counts CLK_DIV sysclk cycles per half-period.
  - SCK rises at k+CLK_DIV and falls at k+2*CLK_DIV, repeating.
  - sdi advances to the next lower bit on each SCK falling edge. The DAC samples on rising edges, so there are 16 rising edges.
  - On the 16th falling edge (k+32*CLK_DIV): cs_n=1, sdi=0, ld_n=0, enter LATCH.
- LATCH: ld_n held low for CLK_DIV cycles.
  - At k+33*CLK_DIV: ld_n=1, done=1 for one cycle.
  - If nothing is pending: busy=0 and go to IDLE.
  - If a sample is pending: reload it into the shift register in that same cycle, go to SHIFT with that edge as the new k, and busy stays 1.
- Frame period = 33*CLK_DIV cycles (825 at default), well under the audio sample period.
- load while busy: data_in is captured into the pending register.
  - If the pending register is already full, it is overwritten (newest wins) and overrun is set.
- load in the same cycle LATCH completes: the sample goes to pending and is started immediately by the LATCH->SHIFT rule. No loss, no overrun.
- load in IDLE with nothing pending: starts directly; the pending register is untouched.
- done and load are independent; done never asserts without a completed 16-bit frame.

Decomposition:
- Shared package (dac_pkg):
  - FSM state encoding (IDLE, SHIFT, LATCH).
  - Command bit position constants: CMD_WR=15, CMD_BUF=14, CMD_GA=13, CMD_SHDN=12, DATA_MSB=11.
  - FRAME_BITS=16.
- One sub-module: spi_tick_gen.
  - Function: CLK_DIV down-counter with enable, emitting a one-cycle tick per half-period.
  - Reset and enable clear it, so the first tick lands exactly CLK_DIV cycles after frame start.
- FSM, shift register, bit counter and pending buffer live in the top.

Test Plan:
- Reset then idle for 100 cycles -> cs_n=1, sck=0, ld_n=1, busy=0, done=0 throughout.
- CLK_DIV=2, load with data_in=10'h2A5 -> bits sampled on 16 SCK rising edges = 16'h3A94.
  - Also: cs_n low for exactly 64 cycles, ld_n low for 2 cycles, done at k+66.
- Load 10'h000, then later 10'h3FF (defaults) -> frames 16'h3000 and 16'h3FFC; each frame 825 cycles from load to done.
- CLK_DIV=2, load 10'h111, then load 10'h222 mid-frame -> second frame 16'h3888 starts on the done cycle with no IDLE gap; overrun=0.
- Load A, then B and C both mid-frame -> frames A then C; overrun=1 and stays set until reset.
- Assert rst_n low at bit 7 of a frame -> cs_n=1 and sck=0 immediately (asynchronous), no ld_n pulse; the next load produces a clean full frame.
